// File: rtl/sprite_painter.sv
// sprite_painter: scans floor, man-sprite and erase-box pixels out to the VGA
// write port, one pixel per cycle, and returns per-job finish handshakes.
// Optional feature macro: SPRITE_PAINTER_CLIP_EN (suppress plot for off-screen pixels).
module sprite_painter #(
  parameter int         SCREEN_W     = 160,
  parameter int         SCREEN_H     = 120,
  parameter int         FLOOR_Y      = 112,
  parameter int         MAN_H        = 16,
  parameter logic [2:0] FLOOR_COLOUR = 3'b110,
  parameter logic [2:0] MAN_COLOUR   = 3'b001,
  parameter logic [2:0] BG_COLOUR    = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_x,
  input  logic       ld_y,
  input  logic       ld_man_style,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [1:0] style_in,
  input  logic       drawing_floors,
  input  logic       draw_man,
  input  logic       erase,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       draw_floors_finish,
  output logic       drawing_man_finish,
  output logic       erase_finish,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {JOB_FLOOR, JOB_MAN, JOB_ERASE} job_t;

  localparam logic [7:0] FLOOR_W_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] FLOOR_H_LAST = 7'(SCREEN_H - FLOOR_Y - 1);
  localparam logic [7:0] MAN_W_LAST   = 8'd7;
  localparam logic [6:0] MAN_H_LAST   = 7'(MAN_H - 1);
  localparam logic [6:0] LEG_ROW0     = 7'(MAN_H - 4);
  localparam logic [6:0] FLOOR_Y7     = 7'(FLOOR_Y);
`ifdef SPRITE_PAINTER_CLIP_EN
  localparam logic [8:0] SCREEN_W9    = 9'(SCREEN_W);
  localparam logic [7:0] SCREEN_H8    = 8'(SCREEN_H);
`endif

  state_t     state_q, state_d;
  job_t       job_q, job_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [1:0] style_q, style_d;
  logic [7:0] col_q, col_d;
  logic [6:0] row_q, row_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       plot_q, plot_d;
  logic       fin_floor_q, fin_floor_d;
  logic       fin_man_q, fin_man_d;
  logic       fin_erase_q, fin_erase_d;

  logic       cmd_act;
  logic [7:0] x_org, px;
  logic [6:0] y_org, py;
  logic [7:0] leg_mask;
  logic [2:0] pcolour;
  logic       pvis;
  logic       last_col, last_row;

  // Pixel under the counters: address, colour, visibility, end-of-scan flags
  always_comb begin
    cmd_act  = 1'b0;
    x_org    = x_q;
    y_org    = y_q;
    last_col = 1'b0;
    last_row = 1'b0;
    pcolour  = BG_COLOUR;
    unique case (style_q)
      2'd0:    leg_mask = 8'b0110_0110;
      2'd1:    leg_mask = 8'b0001_1000;
      2'd2:    leg_mask = 8'b1100_0011;
      default: leg_mask = 8'b0011_1100;
    endcase
    unique case (job_q)
      JOB_FLOOR: begin
        cmd_act  = drawing_floors;
        x_org    = 8'd0;
        y_org    = FLOOR_Y7;
        last_col = (col_q == FLOOR_W_LAST);
        last_row = (row_q == FLOOR_H_LAST);
        pcolour  = FLOOR_COLOUR;
      end
      JOB_MAN: begin
        cmd_act  = draw_man;
        last_col = (col_q == MAN_W_LAST);
        last_row = (row_q == MAN_H_LAST);
        // Body rows are solid; the bottom four leg rows follow the style mask
        pcolour  = ((row_q < LEG_ROW0) || leg_mask[col_q[2:0]]) ? MAN_COLOUR : BG_COLOUR;
      end
      default: begin
        cmd_act  = erase;
        last_col = (col_q == MAN_W_LAST);
        last_row = (row_q == MAN_H_LAST);
        pcolour  = BG_COLOUR;
      end
    endcase
    px = x_org + col_q;
    py = y_org + row_q;
`ifdef SPRITE_PAINTER_CLIP_EN
    pvis = (({1'b0, x_org} + {1'b0, col_q}) < SCREEN_W9) &&
           (({1'b0, y_org} + {1'b0, row_q}) < SCREEN_H8);
`else
    pvis = 1'b1;
`endif
  end

  // Control FSM next-state, counters, register loads and pixel outputs
  always_comb begin
    state_d      = state_q;
    job_d        = job_q;
    x_d          = x_q;
    y_d          = y_q;
    style_d      = style_q;
    col_d        = col_q;
    row_d        = row_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    plot_d       = 1'b0;
    fin_floor_d  = 1'b0;
    fin_man_d    = 1'b0;
    fin_erase_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ld_x)         x_d     = x_in;
        if (ld_y)         y_d     = y_in;
        if (ld_man_style) style_d = style_in;
        col_d = 8'd0;
        row_d = 7'd0;
        if (drawing_floors) begin
          job_d   = JOB_FLOOR;
          state_d = S_RUN;
        end else if (draw_man) begin
          job_d   = JOB_MAN;
          state_d = S_RUN;
        end else if (erase) begin
          job_d   = JOB_ERASE;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!cmd_act) begin
          state_d = S_IDLE;
        end else begin
          vga_x_d      = px;
          vga_y_d      = py;
          vga_colour_d = pcolour;
          plot_d       = pvis;
          if (last_col) begin
            col_d = 8'd0;
            if (last_row) state_d = S_DONE;
            else          row_d   = row_q + 7'd1;
          end else begin
            col_d = col_q + 8'd1;
          end
        end
      end
      S_DONE: begin
        if (!cmd_act) begin
          state_d = S_IDLE;
        end else begin
          fin_floor_d = (job_q == JOB_FLOOR);
          fin_man_d   = (job_q == JOB_MAN);
          fin_erase_d = (job_q == JOB_ERASE);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      job_q        <= JOB_FLOOR;
      x_q          <= 8'd0;
      y_q          <= 7'd0;
      style_q      <= 2'd0;
      col_q        <= 8'd0;
      row_q        <= 7'd0;
      vga_x_q      <= 8'd0;
      vga_y_q      <= 7'd0;
      vga_colour_q <= 3'd0;
      plot_q       <= 1'b0;
      fin_floor_q  <= 1'b0;
      fin_man_q    <= 1'b0;
      fin_erase_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      job_q        <= job_d;
      x_q          <= x_d;
      y_q          <= y_d;
      style_q      <= style_d;
      col_q        <= col_d;
      row_q        <= row_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      plot_q       <= plot_d;
      fin_floor_q  <= fin_floor_d;
      fin_man_q    <= fin_man_d;
      fin_erase_q  <= fin_erase_d;
    end
  end

  assign vga_x              = vga_x_q;
  assign vga_y              = vga_y_q;
  assign vga_colour         = vga_colour_q;
  assign plot               = plot_q;
  assign draw_floors_finish = fin_floor_q;
  assign drawing_man_finish = fin_man_q;
  assign erase_finish       = fin_erase_q;
  assign busy               = (state_q != S_IDLE);

endmodule

// File: tb/tb_sprite_painter.sv
// Testbench for sprite_painter: directed jobs plus randomized jobs checked
// against a pixel-index reference model of the screen painting rules.
module tb_sprite_painter;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld_x, ld_y, ld_man_style;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [1:0] style_in;
  logic       drawing_floors, draw_man, erase;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot, dff, dmf, ef, busy;

  int n_assert = 0;
  int n_fail   = 0;
  int mx = 0, my = 0, ms = 0;

  always #5 clk = ~clk;

  sprite_painter dut (
    .clk(clk), .reset(reset), .ld_x(ld_x), .ld_y(ld_y), .ld_man_style(ld_man_style),
    .x_in(x_in), .y_in(y_in), .style_in(style_in),
    .drawing_floors(drawing_floors), .draw_man(draw_man), .erase(erase),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot),
    .draw_floors_finish(dff), .drawing_man_finish(dmf), .erase_finish(ef), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] obs_pix();
    return {plot, vga_x, vga_y, vga_colour, dff, dmf, ef};
  endfunction

  // Man sprite colour at sprite-relative (c, r) for a leg style
  function automatic logic [2:0] man_colour(int style, int c, int r);
    bit on;
    if (r < 16 - 4) return 3'b001;
    case (style)
      0:       on = c inside {1, 2, 5, 6};
      1:       on = c inside {3, 4};
      2:       on = c inside {0, 1, 6, 7};
      default: on = c inside {2, 3, 4, 5};
    endcase
    return on ? 3'b001 : 3'b000;
  endfunction

  // Expected output vector for the i-th pixel of a job (0 floor, 1 man, 2 erase)
  function automatic logic [21:0] exp_pix(int job, int i);
    int w, h, ox, oy, c, r, x, y;
    logic [2:0] colour;
    logic p;
    if (job == 0) begin w = 160; h = 8;  ox = 0;  oy = 112; end
    else          begin w = 8;   h = 16; ox = mx; oy = my;  end
    c = i % w;
    r = i / w;
    x = ox + c;
    y = oy + r;
    colour = (job == 0) ? 3'b110 : (job == 2) ? 3'b000 : man_colour(ms, c, r);
    p = 1'b1;
`ifdef SPRITE_PAINTER_CLIP_EN
    if (x >= 160 || y >= 120) p = 1'b0;
`endif
    return {p, 8'(x), 7'(y), colour, 3'b000};
  endfunction

  function automatic logic [2:0] fin_vec(int job);
    return (job == 0) ? 3'b100 : (job == 1) ? 3'b010 : 3'b001;
  endfunction

  task automatic set_cmd(int job, logic v);
    case (job)
      0:       drawing_floors = v;
      1:       draw_man = v;
      default: erase = v;
    endcase
  endtask

  // Present load strobes now; they are sampled at the next rising edge
  task automatic load(int x, int y, int s);
    ld_x = 1'b1; ld_y = 1'b1; ld_man_style = 1'b1;
    x_in = 8'(x); y_in = 7'(y); style_in = 2'(s);
    mx = x & 8'hff; my = y & 7'h7f; ms = s & 3;
  endtask

  task automatic clear_ld();
    ld_x = 1'b0; ld_y = 1'b0; ld_man_style = 1'b0;
  endtask

  // Full job: raise command, check every pixel, finish, hold, release
  task automatic run_job(int job, bit noise, bit both, string tag);
    int n;
    n = (job == 0) ? 1280 : 128;
    set_cmd(job, 1'b1);
    if (both) erase = 1'b1;
    @(negedge clk);
    clear_ld();
    chk({tag, "_start"}, 32'({busy, plot, dff, dmf, ef}), 32'(5'b10000));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, 32'(obs_pix()), 32'(exp_pix(job, i)));
      if (noise && i == 2) begin
        // Loads and foreign commands during a job must have no effect
        ld_x = 1'b1; ld_y = 1'b1; ld_man_style = 1'b1;
        x_in = 8'($urandom); y_in = 7'($urandom); style_in = 2'($urandom);
        if (job != 1) draw_man = 1'b1; else erase = 1'b1;
      end
    end
    @(negedge clk);
    chk({tag, "_fin"}, 32'({busy, plot, dff, dmf, ef}), 32'({2'b10, fin_vec(job)}));
    clear_ld();
    if (job != 1) draw_man = 1'b0;
    if (job != 2) erase = 1'b0;
    @(negedge clk);
    chk({tag, "_hold"}, 32'({busy, plot, dff, dmf, ef}), 32'({2'b10, fin_vec(job)}));
    drawing_floors = 1'b0; draw_man = 1'b0; erase = 1'b0;
    @(negedge clk);
    chk({tag, "_rel"}, 32'({busy, plot, dff, dmf, ef}), 32'(0));
  endtask

  initial begin
    int job;
    reset = 1'b1;
    clear_ld();
    x_in = '0; y_in = '0; style_in = '0;
    drawing_floors = 1'b0; draw_man = 1'b0; erase = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'({busy, obs_pix()}), 32'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 32'({busy, obs_pix()}), 32'(0));

    // Floor job
    run_job(0, 1'b0, 1'b0, "floor");

    // Man at (40,96) style 1, loads in a separate cycle
    load(40, 96, 1);
    @(negedge clk);
    clear_ld();
    run_job(1, 1'b0, 1'b0, "man_40_96");

    // Erase the same box
    run_job(2, 1'b0, 1'b0, "erase_40_96");

    // draw_man and erase together: man wins
    load(12, 20, 2);
    run_job(1, 1'b0, 1'b1, "man_vs_erase");

    // Right edge: x = 156 spills past the screen width
    load(156, 50, 3);
    run_job(1, 1'b0, 1'b0, "man_x156");

    // Abort after 10 plots, then reissue from the start
    load(70, 30, 0);
    draw_man = 1'b1;
    @(negedge clk);
    clear_ld();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_pre", 32'(obs_pix()), 32'(exp_pix(1, i)));
    end
    draw_man = 1'b0;
    @(negedge clk);
    chk("abort", 32'({busy, plot, dff, dmf, ef}), 32'(0));
    repeat (3) @(negedge clk);
    chk("abort_no_fin", 32'({busy, plot, dff, dmf, ef}), 32'(0));
    run_job(1, 1'b0, 1'b0, "man_reissue");

    // Reset in the middle of a floor job
    drawing_floors = 1'b1;
    repeat (50) @(negedge clk);
    reset = 1'b1;
    drawing_floors = 1'b0;
    @(negedge clk);
    chk("reset_mid_run", 32'({busy, obs_pix()}), 32'(0));
    reset = 1'b0;
    mx = 0; my = 0; ms = 0;
    repeat (2) @(negedge clk);
    chk("no_resume", 32'({busy, plot}), 32'(0));
    // Registers were cleared by reset: man job lands at (0,0) style 0
    run_job(1, 1'b0, 1'b0, "man_after_reset");

    // Randomized jobs, some with loads in the same cycle as the command
    for (int k = 0; k < 10; k++) begin
      job = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1)
        load($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 3));
      run_job(job, 1'b1, 1'b0, $sformatf("rand%0d_job%0d", k, job));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
